sr_flip_flop: RTL and testbench

//   Clock-edge SR flip-flop (srFF) with complementary outputs q/qbar.

---
 rtl/sr_flip_flop_pkg.sv | 23 ++
 rtl/sr_flip_flop_if.sv | 13 +
 rtl/sr_flip_flop.sv | 35 +++
 tb/tb_sr_flip_flop.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sr_flip_flop_pkg.sv
// Shared constants and the per-bit next-state rule for the SR flip-flop bank.
// BOTH_* select what a lane does when set and reset are requested together.
package sr_flip_flop_pkg;

  localparam int BOTH_HOLD   = 0;
  localparam int BOTH_SET    = 1;
  localparam int BOTH_RST    = 2;
  localparam int BOTH_TOGGLE = 3;

  // Unknown modes fall through to hold so a bad parameter never produces X.
  function automatic logic sr_next(input logic s, input logic r, input logic q, input int mode);
    if (s && !r) return 1'b1;
    if (!s && r) return 1'b0;
    if (!s && !r) return q;
    case (mode)
      BOTH_SET:    return 1'b1;
      BOTH_RST:    return 1'b0;
      BOTH_TOGGLE: return ~q;
      default:     return q;
    endcase
  endfunction

endpackage

// File: rtl/sr_flip_flop_if.sv
// Set/clear request and complementary state bundle for a bank of SR bits.
// The driver of s/r uses master; the flip-flop bank uses slave.
interface sr_flip_flop_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  modport master (output s, output r, input q, input qbar);
  modport slave  (input s, input r, output q, output qbar);
endinterface

// File: rtl/sr_flip_flop.sv
// Rising-edge SR flip-flop bank with complementary outputs; one-cycle latency,
// synchronous active-high reset overrides s/r, no backpressure (always accepts).
module sr_flip_flop
  import sr_flip_flop_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int               BOTH_MODE = BOTH_HOLD
) (
  input  logic          clk,
  input  logic          rst,
  sr_flip_flop_if.slave bus
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] nxt;

  if (BOTH_MODE < BOTH_HOLD || BOTH_MODE > BOTH_TOGGLE) begin : g_bad_mode
    $warning("sr_flip_flop: BOTH_MODE %0d out of range, s=r=1 will hold", BOTH_MODE);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign nxt[i] = sr_next(bus.s[i], bus.r[i], state[i], BOTH_MODE);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RST_VAL;
    else     state <= nxt;
  end

  // Both outputs come from the one register so they can never disagree.
  assign bus.q    = state;
  assign bus.qbar = ~state;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Bench: directed vector table and corner sequences on a 1-bit hold-mode cell,
// then random traffic on it and on 4-bit banks in every s=r=1 mode.
module tb_sr_flip_flop;

  logic clk;
  logic rst, s, r;
  logic brst;
  logic [3:0] bs, br;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] BANK_RST = 4'b1010;

  sr_flip_flop_if #(.WIDTH(1)) mif ();
  sr_flip_flop_if #(.WIDTH(4)) bif0 ();
  sr_flip_flop_if #(.WIDTH(4)) bif1 ();
  sr_flip_flop_if #(.WIDTH(4)) bif2 ();
  sr_flip_flop_if #(.WIDTH(4)) bif3 ();

  assign mif.s = s;
  assign mif.r = r;
  assign bif0.s = bs; assign bif0.r = br;
  assign bif1.s = bs; assign bif1.r = br;
  assign bif2.s = bs; assign bif2.r = br;
  assign bif3.s = bs; assign bif3.r = br;

  sr_flip_flop #(.WIDTH(1)) dut (.clk(clk), .rst(rst), .bus(mif));
  sr_flip_flop #(.WIDTH(4), .RST_VAL(BANK_RST), .BOTH_MODE(0)) dut_b0 (.clk(clk), .rst(brst), .bus(bif0));
  sr_flip_flop #(.WIDTH(4), .RST_VAL(BANK_RST), .BOTH_MODE(1)) dut_b1 (.clk(clk), .rst(brst), .bus(bif1));
  sr_flip_flop #(.WIDTH(4), .RST_VAL(BANK_RST), .BOTH_MODE(2)) dut_b2 (.clk(clk), .rst(brst), .bus(bif2));
  sr_flip_flop #(.WIDTH(4), .RST_VAL(BANK_RST), .BOTH_MODE(3)) dut_b3 (.clk(clk), .rst(brst), .bus(bif3));

  logic [3:0] bq [4];
  logic [3:0] bqb[4];
  assign bq[0] = bif0.q; assign bqb[0] = bif0.qbar;
  assign bq[1] = bif1.q; assign bqb[1] = bif1.qbar;
  assign bq[2] = bif2.q; assign bqb[2] = bif2.qbar;
  assign bq[3] = bif3.q; assign bqb[3] = bif3.qbar;

  initial begin
    clk = 1'b0;
    #16;
    forever begin
      clk = 1'b1; #8;
      clk = 1'b0; #8;
    end
  end

  // Reference: a bit ends up 1 if held at 1, set alone, or both requested with the mode saying 1.
  function automatic logic [3:0] ref_next(input logic [3:0] q, input logic [3:0] sv, input logic [3:0] rv,
                                          input logic rs, input int mode, input logic [3:0] rval);
    logic [3:0] both;
    if (rs) return rval;
    case (mode)
      1:       both = 4'hF;
      2:       both = 4'h0;
      3:       both = ~q;
      default: both = q;
    endcase
    return (q & ~sv & ~rv) | (sv & ~rv) | (sv & rv & both);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_main(input string name, input logic exp_q);
    check({name, ".q"}, {3'b0, mif.q}, {3'b0, exp_q});
    check({name, ".qbar"}, {3'b0, mif.qbar}, {3'b0, ~exp_q});
  endtask

  // Advance past one rising edge and settle mid-cycle for sampling and driving.
  task automatic step();
    @(posedge clk);
    #4;
  endtask

  typedef struct {
    logic rs;
    logic sv;
    logic rv;
    logic q;
  } vec_t;

  vec_t vecs[10];
  logic       mq;
  logic [3:0] bm[4];
  logic [3:0] nb;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0};  // reset beats set
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1};  // set
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1};  // hold 1
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1};  // both from 1 holds
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0};  // clear
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0};  // both from 0 holds
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0};  // reset with set pending

    rst = 1'b1; s = 1'b0; r = 1'b0;
    brst = 1'b1; bs = 4'h0; br = 4'h0;
    #4;

    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rs; s = vecs[i].sv; r = vecs[i].rv;
      step();
      check_main($sformatf("vec%0d", i), vecs[i].q);
      for (int m = 0; m < 4; m++) begin
        check($sformatf("bank%0d_rst.q", m), bq[m], BANK_RST);
        check($sformatf("bank%0d_rst.qbar", m), bqb[m], ~BANK_RST);
      end
    end

    // Pulses that start and end between edges must be ignored.
    rst = 1'b0; s = 1'b0; r = 1'b0;
    s = 1'b1; #2; s = 1'b0;
    step();
    check_main("set_glitch", 1'b0);
    s = 1'b1;
    step();
    check_main("set_after_glitch", 1'b1);
    s = 1'b0;
    r = 1'b1; #2; r = 1'b0;
    step();
    check_main("clr_glitch", 1'b1);
    rst = 1'b1; #2; rst = 1'b0;
    step();
    check_main("rst_glitch", 1'b1);

    mq = 1'b1;
    brst = 1'b0;
    for (int m = 0; m < 4; m++) bm[m] = BANK_RST;

    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 15) == 0);
      s    = 1'($urandom);
      r    = 1'($urandom);
      brst = ($urandom_range(0, 19) == 0);
      bs   = 4'($urandom);
      br   = 4'($urandom);
      nb   = ref_next({3'b0, mq}, {3'b0, s}, {3'b0, r}, rst, 0, 4'h0);
      mq   = nb[0];
      for (int m = 0; m < 4; m++) bm[m] = ref_next(bm[m], bs, br, brst, m, BANK_RST);
      step();
      check_main($sformatf("rnd%0d_main", c), mq);
      for (int m = 0; m < 4; m++) begin
        check($sformatf("rnd%0d_bank%0d.q", c, m), bq[m], bm[m]);
        check($sformatf("rnd%0d_bank%0d.qbar", c, m), bqb[m], ~bm[m]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
